// File: rtl/laser_pkg.sv
// laser_pkg: shared constants and types for the LASER cover scorer
package laser_pkg;
    localparam int CW = 4;
    localparam int NPTS = 40;
    localparam int RSQ = 16;
    localparam int PW = $clog2(NPTS + 1);
    typedef logic [CW-1:0] coord_t;
    typedef logic [PW-1:0] cnt_t;
    typedef struct packed {
        coord_t x;
        coord_t y;
    } point_t;
    typedef enum logic [1:0] {LOAD, WAIT_DONE, SCORE} scorer_state_t;
endpackage

// File: rtl/laser_dist_chk.sv
// laser_dist_chk: flags a point lying within the squared radius of a centre
module laser_dist_chk
    import laser_pkg::*;
(
    input  point_t p,
    input  point_t c,
    output logic   in_range
);
    logic signed [CW:0] dx, dy;
    logic signed [2*CW-1:0] wx, wy;
    logic [2*CW-1:0] sx, sy;
    logic [2*CW:0] d;
    // signed differences, squared and summed without overflow
    always_comb begin
        dx = $signed({1'b0, p.x}) - $signed({1'b0, c.x});
        dy = $signed({1'b0, p.y}) - $signed({1'b0, c.y});
        wx = (2*CW)'(dx);
        wy = (2*CW)'(dy);
        sx = wx * wx;
        sy = wy * wy;
        d = {1'b0, sx} + {1'b0, sy};
        in_range = d <= (2*CW+1)'(RSQ);
    end
endmodule

// File: rtl/laser_cover_scorer.sv
// laser_cover_scorer: stores one image of points and counts those covered by two centres
module laser_cover_scorer
    import laser_pkg::*;
(
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          IN_VALID,
    input  logic [CW-1:0] X,
    input  logic [CW-1:0] Y,
    input  logic          DONE,
    input  logic [CW-1:0] C1X,
    input  logic [CW-1:0] C1Y,
    input  logic [CW-1:0] C2X,
    input  logic [CW-1:0] C2Y,
    output logic [5:0]    COVER,
    output logic          SCORE_VALID,
    output logic          BUSY,
    output logic          ERR
);
    scorer_state_t state, state_next;
    point_t mem [NPTS];
    point_t c1, c2;
    cnt_t wr_ptr, rd_ptr, acc, acc_next;
    logic hit1, hit2, wr_last, rd_last;

    assign wr_last = IN_VALID && wr_ptr == cnt_t'(NPTS - 1);
    assign rd_last = rd_ptr == cnt_t'(NPTS - 1);
    assign acc_next = acc + cnt_t'(hit1 | hit2);
    assign BUSY = state == SCORE;

    laser_dist_chk u_chk1 (.p(mem[rd_ptr]), .c(c1), .in_range(hit1));
    laser_dist_chk u_chk2 (.p(mem[rd_ptr]), .c(c2), .in_range(hit2));

    // state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            state <= LOAD;
        else
            state <= state_next;
    end

    // next state: fill, wait for centres, then one point per clock
    always_comb begin
        state_next = state;
        state_next = (state == LOAD && wr_last)  ? WAIT_DONE :
                     (state == WAIT_DONE && DONE) ? SCORE :
                     (state == SCORE && rd_last)  ? LOAD : state;
    end

    // point storage, written in arrival order and never reset
    always_ff @(posedge CLK) begin
        if (state == LOAD && IN_VALID)
            mem[wr_ptr] <= point_t'({X, Y});
    end

    // pointers, accumulator, centre latches and outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            acc <= '0;
            c1 <= '0;
            c2 <= '0;
            COVER <= '0;
            SCORE_VALID <= 1'b0;
            ERR <= 1'b0;
        end else begin
            SCORE_VALID <= 1'b0;
            case (state)
                LOAD: begin
                    if (wr_last) begin
                        wr_ptr <= cnt_t'(NPTS);
                    end else if (DONE) begin
                        ERR <= 1'b1;
                        wr_ptr <= '0;
                    end else if (IN_VALID) begin
                        wr_ptr <= wr_ptr + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (DONE) begin
                        c1 <= point_t'({C1X, C1Y});
                        c2 <= point_t'({C2X, C2Y});
                        rd_ptr <= '0;
                        acc <= '0;
                    end
                end
                SCORE: begin
                    if (rd_last) begin
                        COVER <= acc_next;
                        SCORE_VALID <= 1'b1;
                        wr_ptr <= '0;
                    end else begin
                        rd_ptr <= rd_ptr + 1'b1;
                        acc <= acc_next;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_laser_cover_scorer.sv
// tb_laser_cover_scorer: directed images checked cycle by cycle against a point-list model
module tb_laser_cover_scorer;
    import laser_pkg::*;

    logic CLK = 1'b0, RST_N = 1'b0, IN_VALID = 1'b0, DONE = 1'b0;
    logic [CW-1:0] X = '0, Y = '0, C1X = '0, C1Y = '0, C2X = '0, C2Y = '0;
    logic [5:0] COVER;
    logic SCORE_VALID, BUSY, ERR;

    laser_cover_scorer dut (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .X(X), .Y(Y), .DONE(DONE),
        .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
        .COVER(COVER), .SCORE_VALID(SCORE_VALID), .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_cmp = 0, n_fail = 0;
    int bs = 0, be = 0, sv_at = -1, err_from = -1, prev_cover = 0, pend = 0, last_model = 0;
    int pin_seq = 0, seen = 0, pin_exp = 0, pin_model = 0;
    string pin_name = "";
    int qx[$], qy[$];

    // covered-point count of the loaded image, straight from the radius rule
    function automatic int model_cover(int ax, int ay, int bx, int by);
        int n = 0;
        foreach (qx[i]) begin
            int d1 = (qx[i] - ax) * (qx[i] - ax) + (qy[i] - ay) * (qy[i] - ay);
            int d2 = (qx[i] - bx) * (qx[i] - bx) + (qy[i] - by) * (qy[i] - by);
            if (d1 <= RSQ || d2 <= RSQ) n++;
        end
        return n;
    endfunction

    task automatic chk(string nm, int got, int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, got, exp);
        end
    endtask

    // every cycle: outputs against the expectation timeline, plus pinned literals
    always @(negedge CLK) begin
        chk("busy", int'(BUSY), (cyc >= bs && cyc < be) ? 1 : 0);
        chk("score_valid", int'(SCORE_VALID), (cyc == sv_at) ? 1 : 0);
        chk("cover", int'(COVER), (sv_at >= 0 && cyc >= sv_at) ? pend : prev_cover);
        chk("err", int'(ERR), (err_from >= 0 && cyc >= err_from) ? 1 : 0);
        if (pin_seq != seen) begin
            seen = pin_seq;
            chk({pin_name, " cover"}, int'(COVER), pin_exp);
            chk({pin_name, " model"}, pin_model, pin_exp);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_pt(int x, int y);
        IN_VALID = 1'b1;
        X = CW'(x);
        Y = CW'(y);
        if (qx.size() < NPTS) begin
            qx.push_back(x);
            qy.push_back(y);
        end
        tick();
        IN_VALID = 1'b0;
    endtask

    task automatic pulse_done(int ax, int ay, int bx, int by);
        int e0 = cyc + 1;
        DONE = 1'b1;
        C1X = CW'(ax);
        C1Y = CW'(ay);
        C2X = CW'(bx);
        C2Y = CW'(by);
        if (qx.size() == NPTS) begin
            prev_cover = (sv_at >= 0 && cyc >= sv_at) ? pend : prev_cover;
            pend = model_cover(ax, ay, bx, by);
            last_model = pend;
            sv_at = e0 + NPTS;
            bs = e0;
            be = e0 + NPTS;
        end else if (err_from < 0) begin
            err_from = e0;
        end
        qx.delete();
        qy.delete();
        tick();
        DONE = 1'b0;
    endtask

    task automatic pin(string nm, int exp);
        pin_name = nm;
        pin_exp = exp;
        pin_model = last_model;
        pin_seq++;
    endtask

    task automatic load_rows();
        for (int r = 0; r < 2; r++)
            for (int x = 0; x < 10; x++) push_pt(x, 0);
        for (int r = 0; r < 2; r++)
            for (int x = 0; x < 10; x++) push_pt(x, 15);
    endtask

    initial begin
        tick();
        tick();
        RST_N = 1'b1;
        tick();
        // all points on centre 1
        for (int i = 0; i < NPTS; i++) push_pt(5, 5);
        tick();
        pulse_done(5, 5, 0, 0);
        repeat (NPTS + 1) tick();
        pin("all_on_c1", 40);
        tick();
        // two rows, only the low end of the bottom row is covered
        load_rows();
        pulse_done(0, 0, 15, 15);
        repeat (NPTS + 1) tick();
        pin("rows", 10);
        tick();
        // radius boundary: 16 in, 18 and 17 out
        push_pt(4, 0);
        push_pt(3, 3);
        push_pt(4, 1);
        for (int i = 3; i < NPTS; i++) push_pt(10, 10);
        pulse_done(0, 0, 15, 15);
        repeat (NPTS + 1) tick();
        pin("boundary", 1);
        tick();
        // identical centres count each point once
        for (int i = 0; i < NPTS; i++) push_pt(i % 10, 7);
        pulse_done(4, 7, 4, 7);
        repeat (NPTS + 1) tick();
        pin("same_centres", 36);
        tick();
        // early DONE sets ERR; the following full image still scores
        for (int i = 0; i < 20; i++) push_pt(1, 1);
        pulse_done(0, 0, 0, 0);
        repeat (3) tick();
        for (int i = 0; i < NPTS; i++) push_pt(i % 10, 7);
        pulse_done(9, 3, 0, 7);
        repeat (NPTS + 1) tick();
        pin("after_err", 24);
        tick();
        // reset in the middle of scoring
        for (int i = 0; i < NPTS; i++) push_pt(5, 5);
        pulse_done(5, 5, 0, 0);
        repeat (10) tick();
        #1;
        RST_N = 1'b0;
        bs = 0;
        be = 0;
        sv_at = -1;
        err_from = -1;
        prev_cover = 0;
        pend = 0;
        tick();
        tick();
        RST_N = 1'b1;
        tick();
        load_rows();
        pulse_done(0, 0, 15, 15);
        repeat (NPTS + 1) tick();
        pin("after_reset", 10);
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
